// File: rtl/adc_avg_filter.sv
// Boxcar moving-average filter over the last 2**LOG2N ADC samples.
// Optional macro ADC_PEAK_HOLD_EN adds running peak_max/peak_min outputs.
module adc_avg_filter #(
    parameter int DW    = 8,
    parameter int LOG2N = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    input  logic          clr,
    output logic [DW-1:0] avg_out,
    output logic          avg_vld,
    output logic          full
`ifdef ADC_PEAK_HOLD_EN
    ,
    output logic [DW-1:0] peak_max,
    output logic [DW-1:0] peak_min
`endif
);

    localparam int N  = 1 << LOG2N;
    localparam int SW = DW + LOG2N;

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   cnt_q, cnt_d;
    logic [LOG2N-1:0]   wptr_q, wptr_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic [DW-1:0]      buf_q [N];
    logic [DW-1:0]      buf_d [N];
    logic               s1_vld_q, s1_vld_d;
    logic               full_q, full_d;
    logic [DW-1:0]      avg_q, avg_d;
    logic               avg_vld_q, avg_vld_d;
`ifdef ADC_PEAK_HOLD_EN
    logic [DW-1:0]      pmax_q, pmax_d;
    logic [DW-1:0]      pmin_q, pmin_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        sum_d     = sum_q;
        buf_d     = buf_q;
        s1_vld_d  = 1'b0;
        full_d    = full_q;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
`ifdef ADC_PEAK_HOLD_EN
        pmax_d    = pmax_q;
        pmin_d    = pmin_q;
`endif
        if (clr) begin
            // Soft flush mirrors reset; any same-cycle sample is dropped
            state_d = FILL;
            cnt_d   = '0;
            wptr_d  = '0;
            sum_d   = '0;
            full_d  = 1'b0;
            avg_d   = '0;
            for (int i = 0; i < N; i++) begin
                buf_d[i] = '0;
            end
`ifdef ADC_PEAK_HOLD_EN
            pmax_d  = '0;
            pmin_d  = '1;
`endif
        end else begin
            if (din_vld) begin
                // Slot being overwritten leaves the window as din enters
                sum_d         = sum_q + SW'(din) - SW'(buf_q[wptr_q]);
                buf_d[wptr_q] = din;
                wptr_d        = wptr_q + 1'b1;
                unique case (state_q)
                    FILL: begin
                        if (cnt_q == LOG2N'(N - 1)) begin
                            state_d  = RUN;
                            cnt_d    = '0;
                            full_d   = 1'b1;
                            s1_vld_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    RUN: begin
                        s1_vld_d = 1'b1;
                    end
                    default: begin
                        state_d = FILL;
                    end
                endcase
`ifdef ADC_PEAK_HOLD_EN
                if (din > pmax_q) pmax_d = din;
                if (din < pmin_q) pmin_d = din;
`endif
            end
            if (s1_vld_q) begin
                avg_d     = DW'(sum_q >> LOG2N);
                avg_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            wptr_q    <= '0;
            sum_q     <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
            s1_vld_q  <= 1'b0;
            full_q    <= 1'b0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
`ifdef ADC_PEAK_HOLD_EN
            pmax_q    <= '0;
            pmin_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            sum_q     <= sum_d;
            buf_q     <= buf_d;
            s1_vld_q  <= s1_vld_d;
            full_q    <= full_d;
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
`ifdef ADC_PEAK_HOLD_EN
            pmax_q    <= pmax_d;
            pmin_q    <= pmin_d;
`endif
        end
    end

    assign avg_out  = avg_q;
    assign avg_vld  = avg_vld_q;
    assign full     = full_q;
`ifdef ADC_PEAK_HOLD_EN
    assign peak_max = pmax_q;
    assign peak_min = pmin_q;
`endif

endmodule

// File: tb/tb_adc_avg_filter.sv
// Bench for adc_avg_filter: queue-based window model checked every cycle
// plus directed vectors with hand-computed averages.
module tb_adc_avg_filter;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       din_vld = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] avg_out;
    logic       avg_vld;
    logic       full;
`ifdef ADC_PEAK_HOLD_EN
    logic [7:0] peak_max;
    logic [7:0] peak_min;
`endif

    int checks = 0;
    int errors = 0;

    adc_avg_filter #(.DW(8), .LOG2N(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .clr     (clr),
        .avg_out (avg_out),
        .avg_vld (avg_vld),
        .full    (full)
`ifdef ADC_PEAK_HOLD_EN
        ,
        .peak_max(peak_max),
        .peak_min(peak_min)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: the window is the last N accepted samples since reset/clr;
    // an average is due one edge after the sample that completes it.
    int  win[$];
    int  pend_due[$];
    int  pend_val[$];
    int  cyc = 0;
    bit  armed = 0;
    bit  exp_vld = 0;
    int  exp_avg = 0;
    bit  exp_full = 0;
    int  exp_pmax = 0;
    int  exp_pmin = 255;

    always @(posedge clk) begin
        cyc++;
        if (rst || clr) begin
            win.delete();
            pend_due.delete();
            pend_val.delete();
            exp_vld  = 0;
            exp_avg  = 0;
            exp_full = 0;
            exp_pmax = 0;
            exp_pmin = 255;
            armed    = 1;
        end else begin
            exp_vld = 0;
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                exp_vld = 1;
                exp_avg = pend_val[0];
                void'(pend_due.pop_front());
                void'(pend_val.pop_front());
            end
            if (din_vld) begin
                int s;
                win.push_back(int'(din));
                if (win.size() > N) void'(win.pop_front());
                if (int'(din) > exp_pmax) exp_pmax = int'(din);
                if (int'(din) < exp_pmin) exp_pmin = int'(din);
                if (win.size() == N) begin
                    s = 0;
                    foreach (win[i]) s += win[i];
                    exp_full = 1;
                    pend_due.push_back(cyc + 1);
                    pend_val.push_back(s / N);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_avg_vld", int'(avg_vld), int'(exp_vld));
            chk("model_avg_out", int'(avg_out), exp_avg);
            chk("model_full", int'(full), int'(exp_full));
`ifdef ADC_PEAK_HOLD_EN
            chk("model_peak_max", int'(peak_max), exp_pmax);
            chk("model_peak_min", int'(peak_min), exp_pmin);
`endif
        end
    end

    int got_q[$];
    always @(negedge clk) begin
        if (avg_vld) got_q.push_back(int'(avg_out));
    end

    task automatic send(input logic [7:0] v);
        din     = v;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    int zexp[8] = '{8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00};
    int a80[4]  = '{8'h48, 8'h50, 8'h58, 8'h60};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_avg_out", int'(avg_out), 0);
        chk("rst_avg_vld", int'(avg_vld), 0);
        chk("rst_full", int'(full), 0);
        rst = 1'b0;
        @(negedge clk);

        // Slow fill with 0x40
        for (int i = 0; i < 8; i++) begin
            send(8'h40);
            @(negedge clk);
            chk("fill40_vld", int'(avg_vld), (i == 7) ? 1 : 0);
            if (i == 7) begin
                chk("fill40_avg", int'(avg_out), 8'h40);
                chk("fill40_full", int'(full), 1);
            end
            repeat (48) @(negedge clk);
        end

        // Running window with 0x80
        for (int i = 0; i < 4; i++) begin
            send(8'h80);
            @(negedge clk);
            chk("run80_vld", int'(avg_vld), 1);
            chk("run80_avg", int'(avg_out), a80[i]);
        end

        // Back-to-back 0xFF then 0x00
        repeat (3) @(negedge clk);
        got_q.delete();
        din_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 8'hFF;
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            din = 8'h00;
            @(negedge clk);
        end
        din_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("burst_count", got_q.size(), 16);
        if (got_q.size() >= 16) begin
            chk("burst_ff", got_q[7], 8'hFF);
            for (int i = 0; i < 8; i++) chk("burst_zero", got_q[8+i], zexp[i]);
        end

        // Truncation: seven 0x01 and one 0x00
        pulse_clr();
        for (int i = 0; i < 8; i++) begin
            send((i == 7) ? 8'h00 : 8'h01);
            @(negedge clk);
            chk("trunc_vld", int'(avg_vld), (i == 7) ? 1 : 0);
        end
        chk("trunc_avg", int'(avg_out), 0);

        // clr with same-cycle sample after 5 of 8
        pulse_clr();
        for (int i = 0; i < 5; i++) send(8'h20);
        din     = 8'hF0;
        din_vld = 1'b1;
        clr     = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        clr     = 1'b0;
        chk("clr_full", int'(full), 0);
        for (int i = 0; i < 8; i++) begin
            send(8'h10);
            @(negedge clk);
            chk("clr_refill_vld", int'(avg_vld), (i == 7) ? 1 : 0);
        end
        chk("clr_refill_avg", int'(avg_out), 8'h10);

        // rst one cycle after the 8th sample
        pulse_clr();
        for (int i = 0; i < 8; i++) send(8'h50);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_vld", int'(avg_vld), 0);
        chk("rst_mid_avg", int'(avg_out), 0);
        chk("rst_mid_full", int'(full), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_late_vld", got_q.size(), 18);

`ifdef ADC_PEAK_HOLD_EN
        pulse_clr();
        send(8'h30);
        send(8'h90);
        send(8'h10);
        chk("peak_max", int'(peak_max), 8'h90);
        chk("peak_min", int'(peak_min), 8'h10);
        pulse_clr();
        chk("peak_max_clr", int'(peak_max), 8'h00);
        chk("peak_min_clr", int'(peak_min), 8'hFF);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
